// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, register indices and write-back state encoding.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd3;
    localparam logic [2:0] STAT_HLT = 3'd4;

    localparam logic [3:0] RRAX  = 4'h0;
    localparam logic [3:0] RRCX  = 4'h1;
    localparam logic [3:0] RRDX  = 4'h2;
    localparam logic [3:0] RRBX  = 4'h3;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RRBP  = 4'h5;
    localparam logic [3:0] RRSI  = 4'h6;
    localparam logic [3:0] RRDI  = 4'h7;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } wb_state_t;

    // Any status outside the defined fault codes is reported as an invalid instruction.
    function automatic logic [2:0] fault_stat(input logic [2:0] s);
        return (s == STAT_ADR || s == STAT_INS || s == STAT_HLT) ? s : STAT_INS;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: NREGS x 64 bits, two asynchronous read ports,
// two synchronous write ports with the M port winning an address conflict.
module y86_regfile #(
    parameter int NREGS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_e,
    input  logic [3:0]  addr_e,
    input  logic [63:0] data_e,
    input  logic        we_m,
    input  logic [3:0]  addr_m,
    input  logic [63:0] data_m,
    input  logic [3:0]  raddr_a,
    input  logic [3:0]  raddr_b,
    output logic [63:0] rdata_a,
    output logic [63:0] rdata_b
);

    logic [63:0] regs_reg [NREGS];
    logic [63:0] rd_tbl   [16];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_reg[gi] <= '0;
                end else if (we_m && addr_m == 4'(gi)) begin
                    regs_reg[gi] <= data_m;
                end else if (we_e && addr_e == 4'(gi)) begin
                    regs_reg[gi] <= data_e;
                end
            end
        end

        // Unimplemented indices (including RNONE) read as zero.
        for (gi = 0; gi < 16; gi++) begin : g_rd
            if (gi < NREGS) begin : g_live
                assign rd_tbl[gi] = regs_reg[gi];
            end else begin : g_zero
                assign rd_tbl[gi] = '0;
            end
        end
    endgenerate

    assign rdata_a = rd_tbl[raddr_a];
    assign rdata_b = rd_tbl[raddr_b];

endmodule

// File: rtl/writeback_regfile.sv
// SEQ write-back stage: gates register commits on AOK status, latches the first
// fault into a sticky halt state and counts retired instructions.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [2:0]       stat_in,
    input  logic [3:0]       dstE,
    input  logic [3:0]       dstM,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [63:0]      valA,
    output logic [63:0]      valB,
    output logic [2:0]       stat_out,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    wb_state_t        state_reg, state_next;
    logic [2:0]       stat_reg, stat_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic             commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            stat_reg    <= STAT_AOK;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            stat_reg    <= stat_next;
            retired_reg <= retired_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        stat_next    = stat_reg;
        retired_next = retired_reg;
        commit       = 1'b0;
        if (state_reg == ST_RUN && wb_valid) begin
            if (stat_in == STAT_AOK) begin
                commit       = 1'b1;
                retired_next = retired_reg + CNT_W'(1);
            end else begin
                stat_next  = fault_stat(stat_in);
                state_next = ST_HALT;
            end
        end
    end

    y86_regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_e    (commit && dstE != RNONE),
        .addr_e  (dstE),
        .data_e  (valE),
        .we_m    (commit && dstM != RNONE),
        .addr_m  (dstM),
        .data_m  (valM),
        .raddr_a (srcA),
        .raddr_b (srcB),
        .rdata_a (valA),
        .rdata_b (valB)
    );

    assign stat_out = stat_reg;
    assign halted   = (state_reg == ST_HALT);
    assign retired  = retired_reg;

endmodule
